instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
- Parametrised successor to the single-word instruction register of the microprocessor datapath.
- Buffers up to DEPTH fetched instruction words in a FIFO and feeds a current-instruction register (IR) on demand.
- The IR opcode field goes to the control sequencer. The operand field is gated onto the internal bus as a plain gated output, not tristate; the top-level bus mux resolves it.
- Adds flush for jumps, a full/empty handshake and a sticky overflow flag, none of which the single register has.

Parameters:
- OPCODE_W, 4, opcode field width (upper bits of the instruction word)
- OPERAND_W, 4, operand/address field width (lower bits)
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2

Ports:
- MainClock  input  1  system clock; all state updates on the rising edge
- ClearN  input  1  synchronous active-low reset, sampled on the rising edge of MainClock
- LatchInstrReg  input  1  push request: write Data into the FIFO tail
- Data  input  OPCODE_W+OPERAND_W  fetched instruction word
- AdvanceInstr  input  1  pop the FIFO head into the IR
- FlushInstrReg  input  1  discard all queued words and invalidate the IR
- EnableInstrReg  input  1  drive the IR operand onto IB
- ToInstr  output  OPCODE_W  IR opcode to the sequencer
- IB  output  OPERAND_W  IR operand when EnableInstrReg=1, else all zeros
- IRValid  output  1  IR holds a valid instruction
- Full  output  1  FIFO count equals DEPTH
- Empty  output  1  FIFO count equals 0
- Count  output  $clog2(DEPTH+1)  FIFO occupancy
- Overflow  output  1  sticky: a push was rejected

Behaviour:
- Reset (ClearN=0 at an edge):
  - FIFO pointers and Count go to 0; Empty=1, Full=0.
  - IR cleared to 0, so ToInstr=0 and IRValid=0; Overflow=0.
  - All other inputs are ignored during the reset cycle.
  - Reset mid-operation discards all queued words.
- Event priority per edge: ClearN, then FlushInstrReg, then AdvanceInstr/LatchInstrReg.
- Flush (FlushInstrReg=1):
  - Count goes to 0 and IRValid to 0; IR contents are held.
  - Push and advance requested in the same cycle are ignored. Overflow is not set.
  - Overflow itself is not cleared.
- Advance (AdvanceInstr=1):
  - FIFO non-empty: IR <= head word, IRValid <= 1, head pointer increments and wraps modulo DEPTH.
  - FIFO empty: IRValid <= 0, IR contents held, no pointer change.
- Push (LatchInstrReg=1):
  - Accepted if Count<DEPTH, or if a pop happens in the same cycle (full with simultaneous advance is legal; Count stays at DEPTH).
  - Accepted push writes Data at the tail; tail pointer increments and wraps.
  - Rejected push: Data dropped, Overflow <= 1.
- Push plus advance on an empty FIFO: no bypass. IRValid <= 0, the pushed word enters the FIFO, Count becomes 1.
- Count: +1 on accepted push only, -1 on pop only, unchanged on both or neither.
- Outputs:
  - Full and Empty decode combinationally from Count.
  - ToInstr is the registered IR opcode field.
  - IB is combinational from EnableInstrReg and the IR operand field.
- Latency:
  - A word pushed at edge N can be in the IR no earlier than edge N+1, via advance asserted in the following cycle.
  - ToInstr updates in the same cycle as IRValid.
- Instruction word split: Data[OPCODE_W+OPERAND_W-1:OPERAND_W] is the opcode, Data[OPERAND_W-1:0] is the operand.

Test Plan:
- Reset then idle, defaults (4/4/4): ClearN=0 for 1 cycle -> Count=0, Empty=1, Full=0, IRValid=0, ToInstr=0, IB=0, Overflow=0.
- Push 0x1A, 0x2B, then advance twice with EnableInstrReg=1 -> ToInstr=1/IB=A, then ToInstr=2/IB=B, IRValid=1; Count goes 2,1,0. Drop EnableInstrReg -> IB=0.
- Push 5 words 0x31..0x35 with no advance -> Full=1 after the 4th, Count=4, Overflow=1 after the 5th; four advances yield opcodes 3 with operands 1..4, and 0x35 is absent.
- With FIFO full, push 0x77 and advance in the same cycle -> Count stays 4, IR gets the old head, Overflow unchanged, and 0x77 is later read out last.
- Flush with Count=3 and push+advance requested -> Count=0, IRValid=0, pushed word absent, Overflow unchanged.
- ClearN=0 asserted mid-stream with Count=2 and Overflow=1 -> next cycle all reset values. An advance on the empty FIFO after that -> IRValid stays 0.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//   Prefetch FIFO of DEPTH instruction words feeding a current-instruction
//   register (IR). The opcode goes to the control sequencer. The operand is
//   gated onto the internal bus as a plain AND-gated output.
//
// Ports:
//   MainClock       system clock, rising edge
//   ClearN          synchronous active-low reset
//   LatchInstrReg   push Data into FIFO tail
//   Data            fetched instruction word {opcode, operand}
//   AdvanceInstr    pop FIFO head into IR
//   FlushInstrReg   discard queued words, invalidate IR (IR contents held)
//   EnableInstrReg  gate IR operand onto IB
//   ToInstr         IR opcode field
//   IB              IR operand field when enabled, else zero
//   IRValid         IR holds a valid instruction
//   Full / Empty    decoded from Count
//   Count           FIFO occupancy
//   Overflow        sticky rejected-push flag
module instr_prefetch_queue #(
  parameter int OPCODE_W  = 4,
  parameter int OPERAND_W = 4,
  parameter int DEPTH     = 4
) (
  input  logic                          MainClock,
  input  logic                          ClearN,
  input  logic                          LatchInstrReg,
  input  logic [OPCODE_W+OPERAND_W-1:0] Data,
  input  logic                          AdvanceInstr,
  input  logic                          FlushInstrReg,
  input  logic                          EnableInstrReg,
  output logic [OPCODE_W-1:0]           ToInstr,
  output logic [OPERAND_W-1:0]          IB,
  output logic                          IRValid,
  output logic                          Full,
  output logic                          Empty,
  output logic [$clog2(DEPTH+1)-1:0]    Count,
  output logic                          Overflow
);

  localparam int W     = OPCODE_W + OPERAND_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic             overflow_q, overflow_d;

  logic pop;
  logic push_ok;

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    overflow_d = overflow_q;

    pop     = AdvanceInstr && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok = LatchInstrReg && ((count_q < CNT_W'(DEPTH)) || pop);

    if (FlushInstrReg) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      ir_valid_d = 1'b0;
    end else begin
      if (AdvanceInstr) begin
        if (pop) begin
          ir_d       = mem_q[head_q];
          ir_valid_d = 1'b1;
          head_d     = head_q + PTR_W'(1);
        end else begin
          ir_valid_d = 1'b0;
        end
      end

      if (push_ok) begin
        mem_d[tail_q] = Data;
        tail_d        = tail_q + PTR_W'(1);
      end else if (LatchInstrReg) begin
        overflow_d = 1'b1;
      end

      if (push_ok && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge MainClock) begin
    if (!ClearN) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: stale words are unreachable once pointers clear.
  always_ff @(posedge MainClock) begin
    mem_q <= mem_d;
  end

  assign ToInstr  = ir_q[W-1:OPERAND_W];
  assign IB       = EnableInstrReg ? ir_q[OPERAND_W-1:0] : '0;
  assign IRValid  = ir_valid_q;
  assign Count    = count_q;
  assign Full     = (count_q == CNT_W'(DEPTH));
  assign Empty    = (count_q == '0);
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;

  localparam int OPCODE_W  = 4;
  localparam int OPERAND_W = 4;
  localparam int DEPTH     = 4;
  localparam int W         = OPCODE_W + OPERAND_W;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 clear_n = 1'b0;
  logic                 latch = 1'b0;
  logic [W-1:0]         data = '0;
  logic                 adv = 1'b0;
  logic                 flush = 1'b0;
  logic                 en = 1'b0;
  logic [OPCODE_W-1:0]  to_instr;
  logic [OPERAND_W-1:0] ib;
  logic                 ir_valid;
  logic                 full;
  logic                 empty;
  logic [CNT_W-1:0]     count;
  logic                 overflow;

  int vectors = 0;
  int miscompares = 0;

  // scoreboard: words expected to emerge from the FIFO, oldest first
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_ir = '0;
  logic         exp_valid = 1'b0;
  logic         exp_ovf = 1'b0;

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .OPCODE_W(OPCODE_W), .OPERAND_W(OPERAND_W), .DEPTH(DEPTH)
  ) dut (
    .MainClock(clk),
    .ClearN(clear_n),
    .LatchInstrReg(latch),
    .Data(data),
    .AdvanceInstr(adv),
    .FlushInstrReg(flush),
    .EnableInstrReg(en),
    .ToInstr(to_instr),
    .IB(ib),
    .IRValid(ir_valid),
    .Full(full),
    .Empty(empty),
    .Count(count),
    .Overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare every output.
  task automatic cycle(input logic c_n, input logic p, input logic [W-1:0] d,
                       input logic a, input logic f, input logic e);
    logic         do_pop;
    logic         do_push;
    logic [W-1:0] exp_word;
    clear_n = c_n; latch = p; data = d; adv = a; flush = f; en = e;

    if (!c_n) begin
      exp_q.delete();
      exp_ir    = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
    end else if (f) begin
      exp_q.delete();
      exp_valid = 1'b0;
    end else begin
      do_pop  = a && (exp_q.size() > 0);
      do_push = p && ((exp_q.size() < DEPTH) || do_pop);
      if (a) begin
        if (do_pop) begin
          exp_word  = exp_q.pop_front();
          exp_ir    = exp_word;
          exp_valid = 1'b1;
        end else begin
          exp_valid = 1'b0;
        end
      end
      if (do_push) exp_q.push_back(d);
      else if (p) exp_ovf = 1'b1;
    end

    @(posedge clk);
    #1;
    check("count",    32'(count),    32'(exp_q.size()));
    check("empty",    32'(empty),    32'(exp_q.size() == 0));
    check("full",     32'(full),     32'(exp_q.size() == DEPTH));
    check("ir_valid", 32'(ir_valid), 32'(exp_valid));
    check("to_instr", 32'(to_instr), 32'(exp_ir[W-1:OPERAND_W]));
    check("ib",       32'(ib),       e ? 32'(exp_ir[OPERAND_W-1:0]) : 32'd0);
    check("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    // reset then idle
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // two pushes, two advances with bus enable, then drop enable
    cycle(1'b1, 1'b1, 8'h1A, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h2B, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("ir_first", 32'({to_instr, ib}), 32'h1A);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("ir_second", 32'({to_instr, ib}), 32'h2B);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // overfill: 0x35 must be rejected and set Overflow
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    check("full_after_overfill", 32'(full), 32'd1);
    check("ovf_after_overfill", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("last_drained", 32'({to_instr, ib}), 32'h34);

    // full FIFO with simultaneous push and advance
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    check("full_push_adv_ir", 32'({to_instr, ib}), 32'h41);
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("full_push_adv_last", 32'({to_instr, ib}), 32'h77);

    // flush with count 3 and push+advance pending
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // push+advance on empty: no bypass
    cycle(1'b1, 1'b1, 8'h6C, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // reset mid-stream with Count=2 and Overflow=1
    cycle(1'b1, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h63, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // random mix against the model
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 49) != 0), 1'($urandom), 8'($urandom),
            1'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
